pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: EXC_ENTRY, 32'h0000_0040, exception handler entry address.
REQ-002 Parameter: ERET_TYPE, 32'h0000_000e, excepttype code that selects return-from-exception.
REQ-003 Parameter: STALL_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (range 1..65535).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous reset, active-low.
REQ-007 stallreq_if  in  1  fetch stage stall request.
REQ-008 stallreq_id  in  1  decode stage stall request.
REQ-009 stallreq_ex  in  1  execute stage stall request (multi-cycle div/madd).
REQ-010 stallreq_mem  in  1  memory stage stall request (bus wait).
REQ-011 excepttype  in  32  exception code from mem stage; zero = no exception.
REQ-012 cp0_epc  in  32  EPC value used for return-from-exception.
REQ-013 stall  out  6  per-stage hold: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
REQ-014 flush  out  1  pipeline-register clear, one-cycle pulse.
REQ-015 new_pc  out  32  redirect target, valid while flush=1.
REQ-016 stall_timeout  out  1  sticky watchdog flag.
REQ-017 stall_cycles  out  32  saturating count of cycles with stall!=0.
REQ-018 flush_count  out  16  saturating count of flush pulses.

Function
REQ-019 FSM has two states, RUN and FLUSH; reset state RUN.
REQ-020 In RUN with excepttype!=0 at a rising edge, next state SHALL be FLUSH, regardless of any stall request.
REQ-021 In FLUSH the FSM SHALL return to RUN at the next edge unconditionally; excepttype is ignored while in FLUSH.
REQ-022 flush SHALL be 1 exactly in FLUSH (one cycle after the capturing edge), 0 otherwise.
REQ-023 new_pc SHALL be registered at the capturing edge: cp0_epc if excepttype==ERET_TYPE, else EXC_ENTRY; it holds its value until the next capture.
REQ-024 stall SHALL be combinational from requests and state, priority mem>ex>id>if: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-025 In FLUSH, and in RUN when excepttype!=0, stall SHALL be 6'b000000.
REQ-026 stall_cycles SHALL increment by 1 at each edge where stall!=0, saturating at 32'hFFFF_FFFF.
REQ-027 flush_count SHALL increment by 1 at each edge leaving FLUSH, saturating at 16'hFFFF.
REQ-028 A 16-bit run counter SHALL increment at each edge with stall!=0 and clear at each edge with stall==0.
REQ-029 stall_timeout SHALL set at the edge where the run counter reaches STALL_LIMIT and stay 1 until reset; the run counter saturates at STALL_LIMIT.
REQ-030 Exception and stall requests in the same cycle: exception wins, the stall cycle is not counted and the run counter clears.

Reset
REQ-031 rst=0 SHALL immediately force state RUN, flush 0, new_pc 32'h0, stall_timeout 0, stall_cycles 0, flush_count 0, run counter 0, independent of clk.
REQ-032 While rst=0, stall SHALL be 6'b000000.
REQ-033 Reset asserted during FLUSH SHALL drop flush the same instant; after release the FSM starts in RUN with no pending flush.

Verification
REQ-034 stallreq_if=1 and stallreq_mem=1 together, excepttype=0 -> stall=6'b011111; stall_cycles +1 per cycle.
REQ-035 excepttype=32'h1 for one cycle -> next cycle flush=1, new_pc=32'h0000_0040, stall=0; following cycle flush=0, flush_count=1.
REQ-036 excepttype=32'h0000_000e, cp0_epc=32'h8000_1234 -> next cycle flush=1, new_pc=32'h8000_1234.
REQ-037 excepttype held nonzero for 3 cycles -> flush pattern 1,0,1 (FLUSH then RUN recapture), flush_count=2.
REQ-038 STALL_LIMIT=4, stallreq_ex held 4 cycles -> stall_timeout=1 after 4th edge; drop request -> flag stays 1 until rst=0.
REQ-039 rst pulled low mid-FLUSH, no clock edge -> flush=0 and all counters 0 immediately; release -> stall follows requests next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall generation, exception flush/redirect,
// and stall/flush statistics with a sticky consecutive-stall watchdog.
module pipe_ctrl #(
   parameter logic [31:0] EXC_ENTRY   = 32'h0000_0040,
   parameter logic [31:0] ERET_TYPE   = 32'h0000_000e,
   parameter int unsigned STALL_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   localparam logic [0:0]  ST_RUN   = 1'b0;
   localparam logic [0:0]  ST_FLUSH = 1'b1;
   localparam logic [15:0] LIMIT_C  = 16'(STALL_LIMIT);

   logic [0:0]  state_q, state_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic        timeout_q, timeout_d;
   logic [5:0]  stall_s;

   // Stall mask: a pending or in-progress exception overrides every stall request.
   always_comb begin
      stall_s = 6'b000000;
      if (!rst) begin
         stall_s = 6'b000000;
      end else if ((state_q == ST_FLUSH) || (excepttype != 32'd0)) begin
         stall_s = 6'b000000;
      end else if (stallreq_mem) begin
         stall_s = 6'b011111;
      end else if (stallreq_ex) begin
         stall_s = 6'b001111;
      end else if (stallreq_id) begin
         stall_s = 6'b000111;
      end else if (stallreq_if) begin
         stall_s = 6'b000011;
      end else begin
         stall_s = 6'b000000;
      end
   end

   // FSM transition, redirect capture and flush statistics.
   always_comb begin
      state_d       = state_q;
      new_pc_d      = new_pc_q;
      flush_count_d = flush_count_q;
      case (state_q)
         ST_RUN: begin
            if (excepttype != 32'd0) begin
               state_d  = ST_FLUSH;
               new_pc_d = (excepttype == ERET_TYPE) ? cp0_epc : EXC_ENTRY;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
            if (flush_count_q != 16'hFFFF) begin
               flush_count_d = flush_count_q + 16'd1;
            end else begin
               flush_count_d = flush_count_q;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Stall statistics; the run counter only survives uninterrupted stall streaks.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      run_cnt_d      = 16'd0;
      if (stall_s != 6'b000000) begin
         if (stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
         end else begin
            stall_cycles_d = stall_cycles_q;
         end
         if (run_cnt_q >= LIMIT_C) begin
            run_cnt_d = LIMIT_C;
         end else begin
            run_cnt_d = run_cnt_q + 16'd1;
         end
      end else begin
         run_cnt_d = 16'd0;
      end
      timeout_d = timeout_q | (run_cnt_d == LIMIT_C);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_RUN;
         new_pc_q       <= 32'h0000_0000;
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
         run_cnt_q      <= 16'd0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         new_pc_q       <= new_pc_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         run_cnt_q      <= run_cnt_d;
         timeout_q      <= timeout_d;
      end
   end

   assign stall         = stall_s;
   assign flush         = (state_q == ST_FLUSH);
   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;
   assign stall_cycles  = stall_cycles_q;
   assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        sif, sid, sex, smem;
   logic [31:0] exc, epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model state
   bit          m_flush;
   logic [31:0] m_pc;
   longint      m_sc;
   int          m_fc;
   int          m_run;
   bit          m_to;

   pipe_ctrl #(.EXC_ENTRY(32'h0000_0040), .ERET_TYPE(32'h0000_000e), .STALL_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
      .excepttype(exc), .cp0_epc(epc),
      .stall(stall), .flush(flush), .new_pc(new_pc),
      .stall_timeout(stall_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic a, input logic b, input logic c, input logic d,
                         input logic [31:0] e, input logic [31:0] p);
      sif = a; sid = b; sex = c; smem = d; exc = e; epc = p;
   endtask

   function automatic logic [5:0] exp_stall();
      if (!rst || m_flush || exc != 32'd0) return 6'b000000;
      if (smem) return 6'b011111;
      if (sex)  return 6'b001111;
      if (sid)  return 6'b000111;
      if (sif)  return 6'b000011;
      return 6'b000000;
   endfunction

   task automatic model_clear();
      m_flush = 1'b0; m_pc = 32'h0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
   endtask

   // One clock edge, advancing the model with the inputs present at that edge
   task automatic tick();
      logic [5:0] s;
      s = exp_stall();
      @(posedge clk);
      if (s != 6'b000000) begin
         if (m_sc < 64'h0000_0000_FFFF_FFFF) m_sc++;
         m_run = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
      end else begin
         m_run = 0;
      end
      if (m_run == LIMIT) m_to = 1'b1;
      if (m_flush) begin
         m_flush = 1'b0;
         if (m_fc < 65535) m_fc++;
      end else if (exc != 32'd0) begin
         m_flush = 1'b1;
         m_pc = (exc == 32'h0000_000e) ? epc : 32'h0000_0040;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      model_clear();
      #7;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
      rst = 1'b0;
      #1;
      n_chk++; if (stall !== 6'b000000) begin n_err++; $display("FAIL reset_stall got=%b exp=000000", stall); end
      n_chk++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%b exp=0", flush); end
      n_chk++; if (new_pc !== 32'h0) begin n_err++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
      n_chk++; if (stall_cycles !== 32'd0 || flush_count !== 16'd0 || stall_timeout !== 1'b0) begin
         n_err++; $display("FAIL reset_counters got sc=%0d fc=%0d to=%b exp 0/0/0", stall_cycles, flush_count, stall_timeout);
      end
      @(posedge clk); #1;
      n_chk++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_hold_sc got=%0d exp=0", stall_cycles); end
      do_reset();
   endtask

   task automatic test_priority();
      logic [5:0] tbl [5];
      logic [3:0] req [5];
      do_reset();
      req[0] = 4'b1001; tbl[0] = 6'b011111;   // {mem,ex,id,if}: if+mem
      req[1] = 4'b0111; tbl[1] = 6'b001111;
      req[2] = 4'b0011; tbl[2] = 6'b000111;
      req[3] = 4'b0001; tbl[3] = 6'b000011;
      req[4] = 4'b0000; tbl[4] = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         set_in(req[i][0], req[i][1], req[i][2], req[i][3], 32'd0, 32'd0);
         #1;
         n_chk++; if (stall !== tbl[i]) begin n_err++; $display("FAIL prio_%0d got=%b exp=%b", i, stall, tbl[i]); end
         tick();
      end
      n_chk++; if (stall_cycles !== 32'd4) begin n_err++; $display("FAIL prio_stall_cycles got=%0d exp=4", stall_cycles); end
   endtask

   task automatic test_exception();
      do_reset();
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 32'h1234_5678);
      #1;
      n_chk++; if (stall !== 6'b000000) begin n_err++; $display("FAIL exc_masks_stall got=%b exp=000000", stall); end
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      #1;
      n_chk++; if (flush !== 1'b1) begin n_err++; $display("FAIL exc_flush got=%b exp=1", flush); end
      n_chk++; if (new_pc !== 32'h0000_0040) begin n_err++; $display("FAIL exc_new_pc got=%h exp=00000040", new_pc); end
      n_chk++; if (stall !== 6'b000000) begin n_err++; $display("FAIL exc_flush_stall got=%b exp=000000", stall); end
      n_chk++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL exc_not_counted got=%0d exp=0", stall_cycles); end
      tick();
      n_chk++; if (flush !== 1'b0 || flush_count !== 16'd1) begin
         n_err++; $display("FAIL exc_after got flush=%b fc=%0d exp 0/1", flush, flush_count);
      end
      n_chk++; if (new_pc !== 32'h0000_0040) begin n_err++; $display("FAIL exc_pc_hold got=%h exp=00000040", new_pc); end
   endtask

   task automatic test_eret();
      do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h8000_1234);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);
      n_chk++; if (flush !== 1'b1 || new_pc !== 32'h8000_1234) begin
         n_err++; $display("FAIL eret got flush=%b pc=%h exp 1/80001234", flush, new_pc);
      end
      tick();
   endtask

   task automatic test_held_exception();
      logic fl [3];
      do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         fl[i] = flush;
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      n_chk++; if (fl[0] !== 1'b1 || fl[1] !== 1'b0 || fl[2] !== 1'b1) begin
         n_err++; $display("FAIL held_pattern got=%b%b%b exp=101", fl[0], fl[1], fl[2]);
      end
      tick();
      n_chk++; if (flush_count !== 16'd2) begin n_err++; $display("FAIL held_flush_count got=%0d exp=2", flush_count); end
   endtask

   task automatic test_timeout();
      do_reset();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      n_chk++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early got=%b exp=0", stall_timeout); end
      tick();
      n_chk++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set got=%b exp=1", stall_timeout); end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick(); tick();
      n_chk++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%b exp=1", stall_timeout); end
      n_chk++; if (stall_cycles !== 32'd7) begin n_err++; $display("FAIL timeout_cycles got=%0d exp=7", stall_cycles); end
      rst = 1'b0; #1;
      n_chk++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_reset got=%b exp=0", stall_timeout); end
      do_reset();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      tick(); tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h3, 32'd0);
      tick();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      n_chk++; if (flush !== 1'b1 || stall_cycles !== 32'd2) begin
         n_err++; $display("FAIL midflush_pre got flush=%b sc=%0d exp 1/2", flush, stall_cycles);
      end
      #2; rst = 1'b0; #1;
      n_chk++; if (flush !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 16'd0 || new_pc !== 32'h0) begin
         n_err++; $display("FAIL midflush_rst got flush=%b sc=%0d fc=%0d pc=%h exp all 0", flush, stall_cycles, flush_count, new_pc);
      end
      model_clear();
      rst = 1'b1; #1;
      n_chk++; if (stall !== 6'b000111 || flush !== 1'b0) begin
         n_err++; $display("FAIL midflush_release got stall=%b flush=%b exp 000111/0", stall, flush);
      end
      tick();
      n_chk++; if (stall_cycles !== 32'd1 || flush !== 1'b0) begin
         n_err++; $display("FAIL midflush_after got sc=%0d flush=%b exp 1/0", stall_cycles, flush);
      end
   endtask

   task automatic test_random();
      logic [31:0] e;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0: e = 32'h0000_000e;
            1: e = $urandom | 32'h1;
            default: e = 32'd0;
         endcase
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), e, $urandom);
         #1;
         n_chk++; if (stall !== exp_stall()) begin n_err++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall, exp_stall()); end
         tick();
         n_chk++; if (flush !== m_flush || new_pc !== m_pc) begin
            n_err++; $display("FAIL rnd_flush[%0d] got %b/%h exp %b/%h", i, flush, new_pc, m_flush, m_pc);
         end
         n_chk++; if (stall_cycles !== m_sc[31:0] || flush_count !== m_fc[15:0] || stall_timeout !== m_to) begin
            n_err++; $display("FAIL rnd_stats[%0d] got sc=%0d fc=%0d to=%b exp %0d/%0d/%b", i,
                              stall_cycles, flush_count, stall_timeout, m_sc, m_fc, m_to);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      model_clear();
      test_reset();
      test_priority();
      test_exception();
      test_eret();
      test_held_exception();
      test_timeout();
      test_reset_mid_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
